// File: rtl/rat_flag_reg.sv
// RAT MCU flag register: architectural C/Z, shadow C/Z for interrupt save/restore,
// interrupt enable I and an edge-latched pending interrupt gated into int_req.
module rat_flag_reg #(
  parameter logic RST_I    = 1'b0,
  parameter logic RST_SHAD = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic c_in,
  input  logic z_in,
  input  logic c_ld,
  input  logic c_set,
  input  logic c_clr,
  input  logic z_ld,
  input  logic ld_sel,
  input  logic shad_ld,
  input  logic i_set,
  input  logic i_clr,
  input  logic int_in,
  input  logic int_ack,
  output logic c_flag,
  output logic z_flag,
  output logic shad_c,
  output logic shad_z,
  output logic i_flag,
  output logic int_req
);

  logic c_flag_q, c_flag_d;
  logic z_flag_q, z_flag_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  logic i_flag_q, i_flag_d;
  logic pend_q, pend_d;
  logic int_prev_q, int_prev_d;
  logic c_src, z_src, int_rise;

  always_comb begin
    // Restore reads the pre-edge shadow, so a simultaneous shad_ld gives a true swap.
    c_src = ld_sel ? shad_c_q : c_in;
    z_src = ld_sel ? shad_z_q : z_in;

    c_flag_d = c_flag_q;
    if (c_clr) begin
      c_flag_d = 1'b0;
    end else if (c_set) begin
      c_flag_d = 1'b1;
    end else if (c_ld) begin
      c_flag_d = c_src;
    end

    z_flag_d = z_ld ? z_src : z_flag_q;

    shad_c_d = shad_ld ? c_flag_q : shad_c_q;
    shad_z_d = shad_ld ? z_flag_q : shad_z_q;

    i_flag_d = i_flag_q;
    if (i_clr) begin
      i_flag_d = 1'b0;
    end else if (i_set) begin
      i_flag_d = 1'b1;
    end

    // A new edge wins over an acknowledge so the fresh interrupt is not dropped.
    int_rise   = int_in & ~int_prev_q;
    int_prev_d = int_in;
    pend_d     = pend_q;
    if (int_ack) begin
      pend_d = 1'b0;
    end
    if (int_rise) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_flag_q   <= 1'b0;
      z_flag_q   <= 1'b0;
      shad_c_q   <= RST_SHAD;
      shad_z_q   <= RST_SHAD;
      i_flag_q   <= RST_I;
      pend_q     <= 1'b0;
      int_prev_q <= 1'b0;
    end else begin
      c_flag_q   <= c_flag_d;
      z_flag_q   <= z_flag_d;
      shad_c_q   <= shad_c_d;
      shad_z_q   <= shad_z_d;
      i_flag_q   <= i_flag_d;
      pend_q     <= pend_d;
      int_prev_q <= int_prev_d;
    end
  end

  assign c_flag  = c_flag_q;
  assign z_flag  = z_flag_q;
  assign shad_c  = shad_c_q;
  assign shad_z  = shad_z_q;
  assign i_flag  = i_flag_q;
  assign int_req = pend_q & i_flag_q;

endmodule

// File: tb/tb_rat_flag_reg.sv
// Directed table-driven bench for rat_flag_reg; expected values are hand-computed.
module tb_rat_flag_reg;

  logic clk = 1'b0;
  logic rst, c_in, z_in, c_ld, c_set, c_clr, z_ld, ld_sel, shad_ld;
  logic i_set, i_clr, int_in, int_ack;
  logic c_flag, z_flag, shad_c, shad_z, i_flag, int_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rat_flag_reg #(
    .RST_I   (1'b0),
    .RST_SHAD(1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .c_in   (c_in),
    .z_in   (z_in),
    .c_ld   (c_ld),
    .c_set  (c_set),
    .c_clr  (c_clr),
    .z_ld   (z_ld),
    .ld_sel (ld_sel),
    .shad_ld(shad_ld),
    .i_set  (i_set),
    .i_clr  (i_clr),
    .int_in (int_in),
    .int_ack(int_ack),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .shad_c (shad_c),
    .shad_z (shad_z),
    .i_flag (i_flag),
    .int_req(int_req)
  );

  // Input bit positions
  localparam logic [12:0] RST  = 13'h1000;
  localparam logic [12:0] CI   = 13'h0800;
  localparam logic [12:0] ZI   = 13'h0400;
  localparam logic [12:0] CLD  = 13'h0200;
  localparam logic [12:0] CSET = 13'h0100;
  localparam logic [12:0] CCLR = 13'h0080;
  localparam logic [12:0] ZLD  = 13'h0040;
  localparam logic [12:0] SEL  = 13'h0020;
  localparam logic [12:0] SLD  = 13'h0010;
  localparam logic [12:0] ISET = 13'h0008;
  localparam logic [12:0] ICLR = 13'h0004;
  localparam logic [12:0] INT  = 13'h0002;
  localparam logic [12:0] ACK  = 13'h0001;
  localparam logic [12:0] NONE = 13'h0000;

  // Expected outputs packed as {c, z, shad_c, shad_z, i, int_req}
  typedef struct {
    string       name;
    logic [12:0] in;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [12:0] i, logic [5:0] e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    return v;
  endfunction

  task automatic drive(input logic [12:0] v);
    rst     = v[12];
    c_in    = v[11];
    z_in    = v[10];
    c_ld    = v[9];
    c_set   = v[8];
    c_clr   = v[7];
    z_ld    = v[6];
    ld_sel  = v[5];
    shad_ld = v[4];
    i_set   = v[3];
    i_clr   = v[2];
    int_in  = v[1];
    int_ack = v[0];
  endtask

  task automatic step_check(input string name, input logic [12:0] v, input logic [5:0] exp);
    logic [5:0] got;
    drive(v);
    @(posedge clk);
    #1;
    got = {c_flag, z_flag, shad_c, shad_z, i_flag, int_req};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {c,z,sc,sz,i,req}=%b, expected %b", name, got, exp);
    end
  endtask

  initial begin
    drive(NONE);
    @(negedge clk);

    vecs.push_back(mk("reset_all_ones",  13'h1fff,               6'b000000));
    vecs.push_back(mk("alu_aa_plus_aa",  CI | CLD | ZLD,         6'b100000));
    vecs.push_back(mk("alu_ff_plus_01",  CI | ZI | CLD | ZLD,    6'b110000));
    vecs.push_back(mk("hold_no_load",    NONE,                   6'b110000));
    vecs.push_back(mk("c_clr_priority",  CCLR | CSET | CLD | CI, 6'b010000));
    vecs.push_back(mk("c_set_over_ld",   CSET | CLD,             6'b110000));
    vecs.push_back(mk("load_c1_z0",      CI | CLD | ZLD,         6'b100000));
    vecs.push_back(mk("shadow_save",     SLD,                    6'b101000));
    vecs.push_back(mk("load_c0_z1",      ZI | CLD | ZLD,         6'b011000));
    vecs.push_back(mk("swap_restore",    SLD | CLD | ZLD | SEL,  6'b100100));
    vecs.push_back(mk("int_rise_i0",     INT,                    6'b100100));
    vecs.push_back(mk("int_hold_i0",     INT,                    6'b100100));
    vecs.push_back(mk("sei_with_pend",   ISET | INT,             6'b100111));
    vecs.push_back(mk("int_ack",         ACK | INT,              6'b100110));
    vecs.push_back(mk("level_no_retrig", INT,                    6'b100110));
    vecs.push_back(mk("int_drop",        NONE,                   6'b100110));
    vecs.push_back(mk("ack_and_rise",    INT | ACK,              6'b100111));
    vecs.push_back(mk("i_clr_priority",  ISET | ICLR | INT,      6'b100100));

    foreach (vecs[k]) begin
      step_check(vecs[k].name, vecs[k].in, vecs[k].exp);
    end

    // Pending survived the CLI above; SEI re-exposes it, then reset kills it.
    step_check("sei_again",        ISET | INT, 6'b100111);
    step_check("reset_while_pend", RST | INT,  6'b000000);
    // int_prev cleared by reset, so the held level counts as a fresh edge.
    step_check("post_reset_rise",  INT,        6'b000000);
    step_check("post_reset_sei",   ISET | INT, 6'b000011);
    step_check("restore_z_only",   ZLD | SEL,  6'b000011);
    step_check("final_ack",        ACK,        6'b000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rat_flag_reg.md
Name: rat_flag_reg

Overview:
- Flag and interrupt-status register for the RAT MCU, located between the ALU and the control unit.
- Captures the ALU `c` and `z` outputs into architectural C and Z flags.
- Maintains shadow copies of C and Z for interrupt entry and return (save on entry, restore on RETIE).
- Holds the interrupt-enable flag I and an edge-latched pending interrupt; presents a gated interrupt request to the control unit.

Parameters:
- RST_I, 0, reset value of the interrupt-enable flag I.
- RST_SHAD, 0, reset value of both shadow flags.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_in  in  1  carry output of the ALU.
- z_in  in  1  zero output of the ALU.
- c_ld  in  1  load C from the selected source.
- c_set  in  1  force C to 1.
- c_clr  in  1  force C to 0.
- z_ld  in  1  load Z from the selected source.
- ld_sel  in  1  flag load source: 0 = ALU (c_in/z_in), 1 = shadow (restore).
- shad_ld  in  1  copy current C/Z into the shadow registers.
- i_set  in  1  set interrupt enable (SEI).
- i_clr  in  1  clear interrupt enable (CLI or interrupt entry).
- int_in  in  1  external interrupt line, already synchronized to clk.
- int_ack  in  1  control unit has accepted the interrupt; clears pending.
- c_flag  out  1  architectural C.
- z_flag  out  1  architectural Z.
- shad_c  out  1  shadow C.
- shad_z  out  1  shadow Z.
- i_flag  out  1  interrupt enable.
- int_req  out  1  interrupt request to the control unit.

Behaviour:
- Reset:
  - Synchronous; dominates every other input in the same cycle.
  - c_flag = 0, z_flag = 0.
  - shad_c = RST_SHAD, shad_z = RST_SHAD.
  - i_flag = RST_I.
  - Pending interrupt = 0, int_prev = 0, so int_req = 0 on the cycle after reset.
  - Reset mid-sequence discards any pending interrupt and any partial save/restore.
- C update, evaluated at the rising edge:
  - Priority: c_clr > c_set > c_ld.
  - c_ld selects c_in when ld_sel = 0, shad_c when ld_sel = 1.
  - With none of the three asserted, C holds.
- Z update:
  - z_ld selects z_in when ld_sel = 0, shad_z when ld_sel = 1; otherwise Z holds.
  - No set or clear exists for Z.
- Latency: one cycle from a load or set request to the output. All outputs are registered except int_req.
- Shadow:
  - shad_ld copies the pre-edge values of c_flag/z_flag.
  - shad_ld together with a restore (ld_sel = 1 and c_ld/z_ld) performs a true swap: the shadow gets the old flags and the flags get the old shadow.
- I flag:
  - i_clr > i_set; otherwise I holds.
  - Must be written on the edge, never combinationally.
- Pending interrupt:
  - Set on a rising edge of int_in, detected with a registered int_prev.
  - Cleared by int_ack. If int_ack and a new rising edge occur in the same cycle, pending stays 1 so the new interrupt is not lost.
  - Latched even while I = 0.
- int_req = pending AND i_flag (combinational from registers).
  - A pending interrupt with I = 0 asserts int_req immediately after a later SEI.
  - A level held high on int_in produces a single pending event.
- Width rules: all state is single-bit; no arithmetic.

Test Plan:
- Reset: drive rst = 1 with all other inputs at 1 for one cycle -> next cycle c_flag = 0, z_flag = 0, shad_c/shad_z = 0, i_flag = 0, int_req = 0.
- ALU capture: sel = ADD, a = AA, b = AA (ALU gives c = 1, z = 0), c_ld = z_ld = 1, ld_sel = 0 -> c_flag = 1, z_flag = 0 one cycle later. Then FF + 01 -> c_flag = 1, z_flag = 1. With c_ld = z_ld = 0, changing ALU outputs -> flags hold.
- C priority:
  - c_clr = c_set = c_ld = 1 with c_in = 1 -> c_flag = 0.
  - c_set = c_ld = 1 with c_in = 0 -> c_flag = 1.
- Save/restore swap:
  - Set flags to C = 1, Z = 0, then pulse shad_ld -> shad_c = 1, shad_z = 0.
  - Load C = 0, Z = 1 from the ALU.
  - Assert shad_ld + c_ld + z_ld with ld_sel = 1 -> c_flag = 1, z_flag = 0, shad_c = 0, shad_z = 1.
- Interrupt gating:
  - With I = 0, pulse int_in 0 -> 1 and hold it high -> int_req = 0.
  - i_set -> int_req = 1 on the next cycle.
  - int_ack -> int_req = 0; holding int_in high does not re-trigger.
  - Drop int_in, then raise it in the same cycle as int_ack -> int_req stays 1.
- I priority: i_set = i_clr = 1 -> i_flag = 0. Reset asserted while pending = 1 and I = 1 -> int_req = 0 on the next cycle.
